// File: rtl/reg_transfer_sequencer.sv
// reg_transfer_sequencer
//
// Purpose: multi-cycle control sequencer that sits in front of an eight-entry
// register file (R1-R4, S1-S4). It takes one register-transfer command at a
// time and drives the register file's select, enable, function and data
// lines. The file performs one access per cycle. Operands are read back
// through the file's OutA port.
//
// Optional feature macro: REGSEQ_SWAP_EN. When it is defined, SWAP (opcode 110)
// is supported, together with the READ_B and WRITE_B states and the LatB
// register. When it is not defined, opcode 110 is treated as illegal.
//
// Handshake: a command transfers on a rising Clock edge where
// CmdValid & CmdReady are both high. CmdReady is high only in IDLE. Cmd* fields
// are sampled only on that edge, and CmdValid is ignored while Busy is high.
//
// Ports:
//   Clock      in   single clock, rising edge
//   Reset      in   asynchronous active-low reset
//   CmdValid   in   command present
//   CmdReady   out  command can be accepted (IDLE only)
//   CmdOp      in   [2:0] opcode: NOP LDI MOV INC DEC CLR SWAP illegal
//   CmdDst     in   [2:0] destination index, 0-3 = R1-R4, 4-7 = S1-S4
//   CmdSrc     in   [2:0] source index, same encoding
//   CmdImm     in   [15:0] immediate value for LDI
//   RFOutA     in   [15:0] register file OutA (combinational read of RFOutASel)
//   RFOutASel  out  [2:0] OutA select
//   RFOutBSel  out  [2:0] constant 0
//   RFFunSel   out  [2:0] register file function select
//   RFRegSel   out  [3:0] active-low enables {R1,R2,R3,R4}
//   RFScrSel   out  [3:0] active-low enables {S1,S2,S3,S4}
//   RFI        out  [15:0] register file data input
//   Busy       out  high in every state except IDLE
//   Done       out  one-cycle completion pulse
//   Err        out  one-cycle pulse with Done for an illegal opcode
//   dbg_state  out  [2:0] current FSM state encoding (debug)
module reg_transfer_sequencer #(
  parameter logic [2:0] FS_DEC  = 3'b000,
  parameter logic [2:0] FS_INC  = 3'b001,
  parameter logic [2:0] FS_LOAD = 3'b010,
  parameter logic [2:0] FS_CLR  = 3'b011
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        CmdValid,
  output logic        CmdReady,
  input  logic [2:0]  CmdOp,
  input  logic [2:0]  CmdDst,
  input  logic [2:0]  CmdSrc,
  input  logic [15:0] CmdImm,
  input  logic [15:0] RFOutA,
  output logic [2:0]  RFOutASel,
  output logic [2:0]  RFOutBSel,
  output logic [2:0]  RFFunSel,
  output logic [3:0]  RFRegSel,
  output logic [3:0]  RFScrSel,
  output logic [15:0] RFI,
  output logic        Busy,
  output logic        Done,
  output logic        Err,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LDI  = 3'b001;
  localparam logic [2:0] OP_MOV  = 3'b010;
  localparam logic [2:0] OP_INC  = 3'b011;
  localparam logic [2:0] OP_DEC  = 3'b100;
  localparam logic [2:0] OP_CLR  = 3'b101;
`ifdef REGSEQ_SWAP_EN
  localparam logic [2:0] OP_SWAP = 3'b110;
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ_A  = 3'd1,
    READ_B  = 3'd2,
    WRITE_A = 3'd3,
    WRITE_B = 3'd4,
    FIN     = 3'd5
  } state_t;

  state_t      state;
  logic [2:0]  dst_q;
  logic [15:0] lat_a;
`ifdef REGSEQ_SWAP_EN
  logic [2:0]  src_q;
  logic        swap_q;
  logic [15:0] lat_b;
`endif

  assign RFOutBSel = 3'b000;
  assign dbg_state = state;

  // Active-low one-hot enable over {RFRegSel, RFScrSel}. Index 0 (R1) maps to
  // bit 7, and index 7 (S4) maps to bit 0.
  function automatic logic [7:0] en_mask(input logic [2:0] idx);
    logic [7:0] m;
    m = 8'hFF;
    m[3'd7 - idx] = 1'b0;
    return m;
  endfunction

  function automatic logic [2:0] fs_for(input logic [2:0] op);
    case (op)
      OP_INC:  return FS_INC;
      OP_DEC:  return FS_DEC;
      OP_CLR:  return FS_CLR;
      default: return FS_LOAD;
    endcase
  endfunction

  // All outputs are registered. Each transition also loads the output values
  // of the state being entered. Write-cycle controls therefore come only from
  // latched fields, the latches, or the accept-edge sample.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      dst_q      <= 3'd0;
      lat_a      <= 16'h0;
`ifdef REGSEQ_SWAP_EN
      src_q      <= 3'd0;
      swap_q     <= 1'b0;
      lat_b      <= 16'h0;
`endif
      CmdReady   <= 1'b1;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Err        <= 1'b0;
      RFOutASel  <= 3'd0;
      RFFunSel   <= 3'd0;
      RFRegSel   <= 4'b1111;
      RFScrSel   <= 4'b1111;
      RFI        <= 16'h0;
    end else begin
      // Non-write defaults; write transitions override them below.
      Done                 <= 1'b0;
      Err                  <= 1'b0;
      {RFRegSel, RFScrSel} <= 8'hFF;
      RFFunSel             <= 3'd0;
      RFI                  <= 16'h0;
      case (state)
        IDLE: begin
          if (CmdValid) begin
            dst_q    <= CmdDst;
`ifdef REGSEQ_SWAP_EN
            src_q    <= CmdSrc;
            swap_q   <= (CmdOp == OP_SWAP);
`endif
            CmdReady <= 1'b0;
            Busy     <= 1'b1;
            case (CmdOp)
              OP_LDI, OP_INC, OP_DEC, OP_CLR: begin
                state                <= WRITE_A;
                {RFRegSel, RFScrSel} <= en_mask(CmdDst);
                RFFunSel             <= fs_for(CmdOp);
                RFI                  <= (CmdOp == OP_LDI) ? CmdImm : 16'h0;
              end
`ifdef REGSEQ_SWAP_EN
              OP_MOV, OP_SWAP: begin
`else
              OP_MOV: begin
`endif
                state     <= READ_A;
                RFOutASel <= CmdSrc;
              end
              default: begin
                // NOP, opcode 111, and 110 when SWAP is not built.
                state <= FIN;
                Done  <= 1'b1;
                Err   <= (CmdOp != OP_NOP);
              end
            endcase
          end
        end
        READ_A: begin
          lat_a <= RFOutA;
`ifdef REGSEQ_SWAP_EN
          if (swap_q) begin
            state     <= READ_B;
            RFOutASel <= dst_q;
          end else
`endif
          begin
            // MOV: forward the value being latched straight onto RFI.
            state                <= WRITE_A;
            {RFRegSel, RFScrSel} <= en_mask(dst_q);
            RFFunSel             <= FS_LOAD;
            RFI                  <= RFOutA;
          end
        end
`ifdef REGSEQ_SWAP_EN
        READ_B: begin
          lat_b                <= RFOutA;
          state                <= WRITE_A;
          {RFRegSel, RFScrSel} <= en_mask(dst_q);
          RFFunSel             <= FS_LOAD;
          RFI                  <= lat_a;
        end
        WRITE_A: begin
          if (swap_q) begin
            state                <= WRITE_B;
            {RFRegSel, RFScrSel} <= en_mask(src_q);
            RFFunSel             <= FS_LOAD;
            RFI                  <= lat_b;
          end else begin
            state <= FIN;
            Done  <= 1'b1;
          end
        end
        WRITE_B: begin
          state <= FIN;
          Done  <= 1'b1;
        end
`else
        WRITE_A: begin
          state <= FIN;
          Done  <= 1'b1;
        end
`endif
        FIN: begin
          state    <= IDLE;
          CmdReady <= 1'b1;
          Busy     <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          CmdReady <= 1'b1;
          Busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_transfer_sequencer.sv
module tb_reg_transfer_sequencer;
  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        CmdValid = 1'b0;
  logic        CmdReady;
  logic [2:0]  CmdOp = 3'd0;
  logic [2:0]  CmdDst = 3'd0;
  logic [2:0]  CmdSrc = 3'd0;
  logic [15:0] CmdImm = 16'h0;
  logic [15:0] RFOutA;
  logic [2:0]  RFOutASel, RFOutBSel, RFFunSel;
  logic [3:0]  RFRegSel, RFScrSel;
  logic [15:0] RFI;
  logic        Busy, Done, Err;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // Register file model: index 0-3 = R1-R4, 4-7 = S1-S4.
  logic [15:0] rf [0:7] = '{8{16'h0}};
  logic [7:0]  sel8;
  assign sel8   = {RFRegSel, RFScrSel};
  assign RFOutA = rf[RFOutASel];

  always @(posedge Clock) begin
    for (int i = 0; i < 8; i++) begin
      if (!sel8[7-i]) begin
        case (RFFunSel)
          3'b000: rf[i] <= rf[i] - 16'd1;
          3'b001: rf[i] <= rf[i] + 16'd1;
          3'b010: rf[i] <= RFI;
          default: rf[i] <= 16'h0;
        endcase
      end
    end
  end

  always #5 Clock = ~Clock;

  reg_transfer_sequencer dut (
    .Clock(Clock), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdOp(CmdOp), .CmdDst(CmdDst), .CmdSrc(CmdSrc), .CmdImm(CmdImm),
    .RFOutA(RFOutA), .RFOutASel(RFOutASel), .RFOutBSel(RFOutBSel),
    .RFFunSel(RFFunSel), .RFRegSel(RFRegSel), .RFScrSel(RFScrSel), .RFI(RFI),
    .Busy(Busy), .Done(Done), .Err(Err), .dbg_state(dbg_state)
  );

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Present a command for one edge. On return the bench is in cycle 1.
  task automatic issue(input logic [2:0] op, input logic [2:0] dst,
                       input logic [2:0] src, input logic [15:0] imm);
    CmdValid = 1'b1; CmdOp = op; CmdDst = dst; CmdSrc = src; CmdImm = imm;
    step();
    CmdValid = 1'b0; CmdOp = 3'd0; CmdDst = 3'd0; CmdSrc = 3'd0; CmdImm = 16'h0;
  endtask

  // LDI, then run through FIN back to IDLE.
  task automatic preload(input logic [2:0] dst, input logic [15:0] imm);
    issue(3'b001, dst, 3'd0, imm);
    step();
    step();
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    #12;
    checks++;
    if ({CmdReady, Busy, Done, Err} !== 4'b1000) begin
      errors++; $display("FAIL reset_flags: got %b want 1000", {CmdReady, Busy, Done, Err});
    end
    checks++;
    if (sel8 !== 8'hFF) begin errors++; $display("FAIL reset_sel: got %h want ff", sel8); end
    checks++;
    if ({RFOutASel, RFFunSel, RFI, RFOutBSel} !== 25'h0) begin
      errors++; $display("FAIL reset_data: asel=%0d fs=%0d rfi=%h bsel=%0d", RFOutASel, RFFunSel, RFI, RFOutBSel);
    end
    checks++;
    if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    @(negedge Clock);
    Reset = 1'b1;
    step();
  endtask

  task automatic test_ldi();
    issue(3'b001, 3'd2, 3'd0, 16'hA5C3);
    checks++;
    if ({sel8, RFFunSel, RFI} !== {8'b1101_1111, 3'b010, 16'hA5C3}) begin
      errors++; $display("FAIL ldi_write: sel=%b fs=%b rfi=%h want 11011111 010 a5c3", sel8, RFFunSel, RFI);
    end
    checks++;
    if ({Busy, CmdReady, Done} !== 3'b100) begin
      errors++; $display("FAIL ldi_busy: busy/ready/done=%b want 100", {Busy, CmdReady, Done});
    end
    step();
    checks++;
    if ({Done, Err} !== 2'b10) begin errors++; $display("FAIL ldi_done: done/err=%b want 10", {Done, Err}); end
    checks++;
    if (rf[2] !== 16'hA5C3) begin errors++; $display("FAIL ldi_r3: got %h want a5c3", rf[2]); end
    step();
    checks++;
    if ({CmdReady, Busy, Done} !== 3'b100) begin
      errors++; $display("FAIL ldi_idle: ready/busy/done=%b want 100", {CmdReady, Busy, Done});
    end
  endtask

  task automatic test_mov();
    preload(3'd4, 16'h1234);
    issue(3'b010, 3'd0, 3'd4, 16'h0);
    checks++;
    if ({RFOutASel, sel8, Done} !== {3'd4, 8'hFF, 1'b0}) begin
      errors++; $display("FAIL mov_read: asel=%0d sel=%h done=%b want 4 ff 0", RFOutASel, sel8, Done);
    end
    step();
    checks++;
    if ({sel8, RFFunSel, RFI} !== {8'b0111_1111, 3'b010, 16'h1234}) begin
      errors++; $display("FAIL mov_write: sel=%b fs=%b rfi=%h want 01111111 010 1234", sel8, RFFunSel, RFI);
    end
    step();
    checks++;
    if (Done !== 1'b1 || rf[0] !== 16'h1234) begin
      errors++; $display("FAIL mov_done: done=%b r1=%h want 1 1234", Done, rf[0]);
    end
    step();
    // src == dst leaves the value unchanged.
    issue(3'b010, 3'd4, 3'd4, 16'h0);
    step();
    step();
    checks++;
    if (Done !== 1'b1 || rf[4] !== 16'h1234) begin
      errors++; $display("FAIL mov_same: done=%b s1=%h want 1 1234", Done, rf[4]);
    end
    step();
  endtask

  task automatic test_swap();
    preload(3'd1, 16'h0001);
    preload(3'd3, 16'hFFFF);
    issue(3'b110, 3'd1, 3'd3, 16'h0);
`ifdef REGSEQ_SWAP_EN
    checks++;
    if (RFOutASel !== 3'd3) begin errors++; $display("FAIL swap_read_a: asel=%0d want 3", RFOutASel); end
    step();
    checks++;
    if (RFOutASel !== 3'd1 || sel8 !== 8'hFF) begin
      errors++; $display("FAIL swap_read_b: asel=%0d sel=%h want 1 ff", RFOutASel, sel8);
    end
    step();
    checks++;
    if ({sel8, RFI} !== {8'b1011_1111, 16'hFFFF}) begin
      errors++; $display("FAIL swap_write_a: sel=%b rfi=%h want 10111111 ffff", sel8, RFI);
    end
    step();
    checks++;
    if ({sel8, RFI} !== {8'b1110_1111, 16'h0001}) begin
      errors++; $display("FAIL swap_write_b: sel=%b rfi=%h want 11101111 0001", sel8, RFI);
    end
    step();
    checks++;
    if ({Done, Err} !== 2'b10 || rf[1] !== 16'hFFFF || rf[3] !== 16'h0001) begin
      errors++; $display("FAIL swap_done: done/err=%b r2=%h r4=%h want 10 ffff 0001", {Done, Err}, rf[1], rf[3]);
    end
    step();
    // src == dst: all four access cycles, value unchanged.
    issue(3'b110, 3'd1, 3'd1, 16'h0);
    step(); step(); step(); step();
    checks++;
    if (Done !== 1'b1 || rf[1] !== 16'hFFFF) begin
      errors++; $display("FAIL swap_same: done=%b r2=%h want 1 ffff", Done, rf[1]);
    end
    step();
`else
    checks++;
    if ({Done, Err, sel8} !== {2'b11, 8'hFF}) begin
      errors++; $display("FAIL swap_illegal: done/err=%b sel=%h want 11 ff", {Done, Err}, sel8);
    end
    step();
    checks++;
    if (rf[1] !== 16'h0001 || rf[3] !== 16'hFFFF || CmdReady !== 1'b1) begin
      errors++; $display("FAIL swap_unchanged: r2=%h r4=%h ready=%b want 0001 ffff 1", rf[1], rf[3], CmdReady);
    end
`endif
  endtask

  task automatic test_inc_dec();
    preload(3'd7, 16'hFFFF);
    issue(3'b011, 3'd7, 3'd0, 16'h0);
    checks++;
    if ({sel8, RFFunSel, RFI} !== {8'b1111_1110, 3'b001, 16'h0}) begin
      errors++; $display("FAIL inc_write: sel=%b fs=%b rfi=%h want 11111110 001 0000", sel8, RFFunSel, RFI);
    end
    step();
    checks++;
    if (Done !== 1'b1 || rf[7] !== 16'h0000) begin
      errors++; $display("FAIL inc_done: done=%b s4=%h want 1 0000", Done, rf[7]);
    end
    step();
    issue(3'b100, 3'd7, 3'd0, 16'h0);
    checks++;
    if ({sel8, RFFunSel} !== {8'b1111_1110, 3'b000}) begin
      errors++; $display("FAIL dec_write: sel=%b fs=%b want 11111110 000", sel8, RFFunSel);
    end
    step();
    checks++;
    if (Done !== 1'b1 || rf[7] !== 16'hFFFF) begin
      errors++; $display("FAIL dec_done: done=%b s4=%h want 1 ffff", Done, rf[7]);
    end
    step();
    issue(3'b101, 3'd7, 3'd0, 16'h0);
    checks++;
    if ({sel8, RFFunSel} !== {8'b1111_1110, 3'b011}) begin
      errors++; $display("FAIL clr_write: sel=%b fs=%b want 11111110 011", sel8, RFFunSel);
    end
    step();
    checks++;
    if (rf[7] !== 16'h0000) begin errors++; $display("FAIL clr_done: s4=%h want 0000", rf[7]); end
    step();
  endtask

  task automatic test_illegal_held();
    CmdValid = 1'b1; CmdOp = 3'b111; CmdDst = 3'd0; CmdImm = 16'h0;
    step();
    checks++;
    if ({Done, Err, sel8, CmdReady} !== {2'b11, 8'hFF, 1'b0}) begin
      errors++; $display("FAIL illegal_fin: done/err=%b sel=%h ready=%b want 11 ff 0", {Done, Err}, sel8, CmdReady);
    end
    // New fields while Busy must be ignored until CmdReady is high again.
    CmdOp = 3'b001; CmdImm = 16'h5A5A;
    step();
    checks++;
    if ({CmdReady, Busy, Done, Err, sel8} !== {4'b1000, 8'hFF}) begin
      errors++; $display("FAIL illegal_idle: ready/busy/done/err=%b sel=%h want 1000 ff", {CmdReady, Busy, Done, Err}, sel8);
    end
    step();
    CmdValid = 1'b0;
    checks++;
    if ({sel8, RFI} !== {8'b0111_1111, 16'h5A5A}) begin
      errors++; $display("FAIL held_accept: sel=%b rfi=%h want 01111111 5a5a", sel8, RFI);
    end
    step();
    step();
  endtask

  task automatic test_reset_mid();
    logic [15:0] snap [0:7];
    for (int i = 0; i < 8; i++) snap[i] = rf[i];
`ifdef REGSEQ_SWAP_EN
    issue(3'b110, 3'd0, 3'd1, 16'h0);
    step();
    checks++;
    if (dbg_state !== 3'd2) begin errors++; $display("FAIL mid_read_b: state=%0d want 2", dbg_state); end
`else
    issue(3'b010, 3'd0, 3'd1, 16'h0);
`endif
    #2;
    Reset = 1'b0;
    #1;
    checks++;
    if ({sel8, CmdReady, Busy, dbg_state} !== {8'hFF, 2'b10, 3'd0}) begin
      errors++; $display("FAIL mid_reset: sel=%h ready/busy=%b state=%0d want ff 10 0", sel8, {CmdReady, Busy}, dbg_state);
    end
    step();
    Reset = 1'b1;
    step();
    step();
    checks++;
    if (CmdReady !== 1'b1 || rf[0] !== snap[0] || rf[1] !== snap[1]) begin
      errors++; $display("FAIL mid_nowrite: ready=%b r1=%h r2=%h want 1 %h %h", CmdReady, rf[0], rf[1], snap[0], snap[1]);
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_mov();
    test_swap();
    test_inc_dec();
    test_illegal_held();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
